multicycle_control: RTL and testbench

//  Multicycle MIPS main controller: Moore FSM + ALU decoder that drives ALUControl into the ALU and

---
 rtl/mc_pkg.sv | 70 +++++++
 rtl/alu_decoder.sv | 33 +++
 rtl/multicycle_control.sv | 144 ++++++++++++++
 tb/tb_multicycle_control.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared constants for the multicycle MIPS controller: opcodes, funct codes, ALU codes, FSM states.
// Latency: n/a (definitions only). Backpressure: n/a.
// Optional feature macro: MC_BNE_EN (adds bne as a legal opcode routed to BRANCH).
package mc_pkg;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;

    // ALUControl encodings driven into the ALU
    localparam logic [3:0] ALUC_AND = 4'b0000;
    localparam logic [3:0] ALUC_OR  = 4'b0001;
    localparam logic [3:0] ALUC_ADD = 4'b0010;
    localparam logic [3:0] ALUC_SUB = 4'b0110;
    localparam logic [3:0] ALUC_SLT = 4'b0111;
    localparam logic [3:0] ALUC_NOR = 4'b1100;

    // ALUOp from the FSM to the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Controller states; one cycle each
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_e;

    // DECODE dispatch: state that follows DECODE for a given opcode.
    // S_FETCH means the opcode is unsupported and is dropped as a nop.
    function automatic state_e decode_target(input logic [5:0] op);
        state_e nxt;
        case (op)
            OP_LW, OP_SW: nxt = S_MEMADR;
            OP_RTYPE:     nxt = S_EXECUTE;
            OP_BEQ:       nxt = S_BRANCH;
`ifdef MC_BNE_EN
            OP_BNE:       nxt = S_BRANCH;
`endif
            OP_ADDI:      nxt = S_ADDIEX;
            OP_J:         nxt = S_JUMP;
            default:      nxt = S_FETCH;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU decoder: maps FSM ALUOp plus R-type funct to the 4-bit ALUControl code.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs every cycle.
module alu_decoder
    import mc_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [5:0] funct_i,
    output logic [3:0] alu_control_o
);

    // Select ALU operation; unknown funct codes quietly fall back to ADD
    always_comb begin
        alu_control_o = ALUC_ADD;
        case (alu_op_i)
            ALUOP_ADD: alu_control_o = ALUC_ADD;
            ALUOP_SUB: alu_control_o = ALUC_SUB;
            ALUOP_FUNCT: begin
                case (funct_i)
                    FUNCT_ADD: alu_control_o = ALUC_ADD;
                    FUNCT_SUB: alu_control_o = ALUC_SUB;
                    FUNCT_AND: alu_control_o = ALUC_AND;
                    FUNCT_OR:  alu_control_o = ALUC_OR;
                    FUNCT_SLT: alu_control_o = ALUC_SLT;
                    FUNCT_NOR: alu_control_o = ALUC_NOR;
                    default:   alu_control_o = ALUC_ADD;
                endcase
            end
            default: alu_control_o = ALUC_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main controller: Moore FSM sequencing fetch/decode/execute/mem/writeback + ALU decoder.
// Latency: lw 5 cycles, sw/R-type/addi 4, beq/bne/j 3 (FETCH to next FETCH).
// Backpressure: none; advances one state per clock. Optional macro MC_BNE_EN enables bne.
module multicycle_control
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic [3:0] ALUControl,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       Illegal
);

    state_e     state_q;
    state_e     state_d;
    logic [1:0] alu_op;
    logic       pc_write;
    logic       branch;
    logic       branch_cond;

    // State register; reset overrides any pending transition
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore control outputs; everything not driven in a state stays 0
    always_comb begin
        state_d  = state_q;
        alu_op   = ALUOP_ADD;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        PCSrc    = 2'b00;
        IorD     = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        Illegal  = 1'b0;
        pc_write = 1'b0;
        branch   = 1'b0;
        case (state_q)
            S_FETCH: begin
                // Load IR from memory[PC] and advance PC by 4
                ALUSrcB  = 2'b01;
                IRWrite  = 1'b1;
                pc_write = 1'b1;
                state_d  = S_DECODE;
            end
            S_DECODE: begin
                // Precompute branch target PC + (SignImm << 2) into ALUOut
                ALUSrcB = 2'b11;
                state_d = decode_target(Op);
                Illegal = (state_d == S_FETCH);
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                IorD    = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                alu_op  = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                // Compare A and B; PC takes ALUOut (target from DECODE) when taken
                ALUSrcA = 1'b1;
                alu_op  = ALUOP_SUB;
                PCSrc   = 2'b01;
                branch  = 1'b1;
                state_d = S_FETCH;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_JUMP: begin
                PCSrc    = 2'b10;
                pc_write = 1'b1;
                state_d  = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

`ifdef MC_BNE_EN
    // bne branches on inequality, beq on equality
    assign branch_cond = (Op == OP_BNE) ? ~Zero : Zero;
`else
    assign branch_cond = Zero;
`endif

    assign PCEn = pc_write | (branch & branch_cond);

    alu_decoder u_alu_decoder (
        .alu_op_i      (alu_op),
        .funct_i       (Funct),
        .alu_control_o (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-cycle expected control vectors via scoreboard queue.
// Latency: checks each instruction's FETCH-to-FETCH cycle count through the expected sequence.
// Backpressure: n/a; honours MC_BNE_EN to choose bne expectations.
module tb_multicycle_control;

    logic       clk;
    logic       reset;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic [3:0] ALUControl;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSrc;
    logic       PCEn;
    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       Illegal;

    multicycle_control dut (
        .clk        (clk),
        .reset      (reset),
        .Op         (Op),
        .Funct      (Funct),
        .Zero       (Zero),
        .ALUControl (ALUControl),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .PCSrc      (PCSrc),
        .PCEn       (PCEn),
        .IorD       (IorD),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .Illegal    (Illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef MC_BNE_EN
    localparam bit BNE_EN = 1'b1;
`else
    localparam bit BNE_EN = 1'b0;
`endif

    // Observed control word: {ALUControl, ALUSrcA, ALUSrcB, PCSrc, PCEn, IorD, MemWrite,
    //                         IRWrite, RegDst, MemtoReg, RegWrite, Illegal}
    logic [16:0] obs;
    assign obs = {ALUControl, ALUSrcA, ALUSrcB, PCSrc, PCEn, IorD, MemWrite,
                  IRWrite, RegDst, MemtoReg, RegWrite, Illegal};

    typedef enum int {
        T_FETCH, T_DECODE, T_MEMADR, T_MEMRD, T_MEMWB, T_MEMWR,
        T_EXECUTE, T_ALUWB, T_BRANCH, T_ADDIEX, T_ADDIWB, T_JUMP
    } tst_e;

    typedef struct {
        string       tag;
        logic [16:0] v;
        logic [16:0] m;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [16:0] got, input logic [16:0] want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %b expected %b", tag, got, want);
        end
    endtask

    function automatic logic [3:0] ref_aluc(input logic [5:0] f);
        case (f)
            6'b100000: return 4'b0010;
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b101010: return 4'b0111;
            6'b100111: return 4'b1100;
            default:   return 4'b0010;
        endcase
    endfunction

    function automatic bit op_legal(input logic [5:0] op);
        return (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000000) ||
               (op == 6'b000100) || (op == 6'b001000) || (op == 6'b000010) ||
               (BNE_EN && op == 6'b000101);
    endfunction

    // Expected control word for one state, built straight from the state table
    function automatic exp_t make_exp(input tst_e st, input logic [5:0] op,
                                      input logic [5:0] f, input logic z);
        exp_t       e;
        logic [3:0] aluc   = 4'b0000;
        logic       care   = 1'b0;
        logic       srca   = 1'b0;
        logic [1:0] srcb   = 2'b00;
        logic [1:0] pcsrc  = 2'b00;
        logic       pcen   = 1'b0;
        logic       iord   = 1'b0;
        logic       memw   = 1'b0;
        logic       irw    = 1'b0;
        logic       regdst = 1'b0;
        logic       m2r    = 1'b0;
        logic       regw   = 1'b0;
        logic       ill    = 1'b0;
        case (st)
            T_FETCH:   begin aluc = 4'b0010; care = 1; srcb = 2'b01; pcen = 1; irw = 1; end
            T_DECODE:  begin aluc = 4'b0010; care = 1; srcb = 2'b11; ill = !op_legal(op); end
            T_MEMADR:  begin aluc = 4'b0010; care = 1; srca = 1; srcb = 2'b10; end
            T_MEMRD:   begin iord = 1; end
            T_MEMWB:   begin regw = 1; m2r = 1; end
            T_MEMWR:   begin iord = 1; memw = 1; end
            T_EXECUTE: begin aluc = ref_aluc(f); care = 1; srca = 1; end
            T_ALUWB:   begin regw = 1; regdst = 1; end
            T_BRANCH:  begin
                aluc = 4'b0110; care = 1; srca = 1; pcsrc = 2'b01;
                pcen = (BNE_EN && op == 6'b000101) ? ~z : z;
            end
            T_ADDIEX:  begin aluc = 4'b0010; care = 1; srca = 1; srcb = 2'b10; end
            T_ADDIWB:  begin regw = 1; end
            T_JUMP:    begin pcsrc = 2'b10; pcen = 1; end
            default:   begin end
        endcase
        e.tag = $sformatf("%s op=%b f=%b z=%b", st.name(), op, f, z);
        e.v   = {aluc, srca, srcb, pcsrc, pcen, iord, memw, irw, regdst, m2r, regw, ill};
        e.m   = care ? 17'h1ffff : 17'h01fff;
        return e;
    endfunction

    task automatic push(input tst_e st, input logic [5:0] op, input logic [5:0] f, input logic z);
        sb.push_back(make_exp(st, op, f, z));
    endtask

    // Expected state walk for one instruction, starting at FETCH
    task automatic push_instr(input logic [5:0] op, input logic [5:0] f, input logic z);
        push(T_FETCH, op, f, z);
        push(T_DECODE, op, f, z);
        case (op)
            6'b100011: begin push(T_MEMADR, op, f, z); push(T_MEMRD, op, f, z); push(T_MEMWB, op, f, z); end
            6'b101011: begin push(T_MEMADR, op, f, z); push(T_MEMWR, op, f, z); end
            6'b000000: begin push(T_EXECUTE, op, f, z); push(T_ALUWB, op, f, z); end
            6'b000100: push(T_BRANCH, op, f, z);
            6'b000101: if (BNE_EN) push(T_BRANCH, op, f, z);
            6'b001000: begin push(T_ADDIEX, op, f, z); push(T_ADDIWB, op, f, z); end
            6'b000010: push(T_JUMP, op, f, z);
            default:   begin end
        endcase
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_underflow", 17'h1, 17'h0);
        end else begin
            e = sb.pop_front();
            check(e.tag, obs & e.m, e.v & e.m);
        end
    endtask

    // Entered #1 after the edge that starts FETCH; leaves at the next FETCH
    task automatic run_instr(input logic [5:0] op, input logic [5:0] f, input logic z);
        Op = op; Funct = f; Zero = z;
        push_instr(op, f, z);
        while (sb.size() > 0) begin
            pop_check();
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1'b1; Op = 6'b0; Funct = 6'b0; Zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        push(T_FETCH, Op, Funct, Zero);
        pop_check();
        @(posedge clk); #1;
        // One throwaway walk so the main sequence starts from a FETCH
        push(T_DECODE, Op, Funct, Zero);
        push(T_EXECUTE, Op, Funct, Zero);
        push(T_ALUWB, Op, Funct, Zero);
        while (sb.size() > 0) begin
            pop_check();
            @(posedge clk); #1;
        end

        // Reset held two cycles starting mid-EXECUTE
        Op = 6'b000000; Funct = 6'b100010; Zero = 1'b0;
        push(T_FETCH, Op, Funct, Zero);
        push(T_DECODE, Op, Funct, Zero);
        push(T_EXECUTE, Op, Funct, Zero);
        repeat (2) begin
            pop_check();
            @(posedge clk); #1;
        end
        pop_check();
        reset = 1'b1;
        @(posedge clk); #1;
        push(T_FETCH, Op, Funct, Zero);
        pop_check();
        @(posedge clk); #1;
        push(T_FETCH, Op, Funct, Zero);
        pop_check();
        reset = 1'b0;
        @(posedge clk); #1;
        push(T_DECODE, Op, Funct, Zero);
        push(T_EXECUTE, Op, Funct, Zero);
        push(T_ALUWB, Op, Funct, Zero);
        while (sb.size() > 0) begin
            pop_check();
            @(posedge clk); #1;
        end

        run_instr(6'b100011, 6'b000000, 1'b0);   // lw
        run_instr(6'b000000, 6'b100010, 1'b0);   // sub
        run_instr(6'b000000, 6'b100000, 1'b1);   // add
        run_instr(6'b000000, 6'b100100, 1'b0);   // and
        run_instr(6'b000000, 6'b100101, 1'b0);   // or
        run_instr(6'b000000, 6'b101010, 1'b0);   // slt
        run_instr(6'b000000, 6'b100111, 1'b0);   // nor
        run_instr(6'b000000, 6'b110011, 1'b0);   // unknown funct -> add
        run_instr(6'b000100, 6'b000000, 1'b1);   // beq taken
        run_instr(6'b000100, 6'b000000, 1'b0);   // beq not taken
        run_instr(6'b101011, 6'b000000, 1'b0);   // sw
        run_instr(6'b000010, 6'b000000, 1'b0);   // j
        run_instr(6'b001000, 6'b000000, 1'b0);   // addi
        run_instr(6'b111111, 6'b000000, 1'b0);   // illegal
        run_instr(6'b000101, 6'b000000, 1'b0);   // bne, Zero=0
        run_instr(6'b000101, 6'b000000, 1'b1);   // bne, Zero=1
        run_instr(6'b100011, 6'b101010, 1'b1);   // lw again after mixed traffic

        // Final FETCH confirms the last instruction returned on time
        push(T_FETCH, Op, Funct, Zero);
        pop_check();
        check("sb_empty", 17'(sb.size()), 17'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
